// File: rtl/lane_request_conditioner_pkg.sv
// Shared lane constants and types for the intersection front end.
package tlc_pkg;

  localparam int NUM_LANES = 4;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;
  localparam int LANE_D = 3;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/lane_request_conditioner_debounce.sv
// One lane: two-flop synchroniser followed by a symmetric counting debouncer.
module lane_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = '0;
    // Any return to the accepted level restarts the stability count.
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/lane_request_conditioner.sv
// Conditions raw lane sensors into latched requests and paces the controller with a tick.
module lane_request_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      sens_raw,
  input  logic [3:0]      green,
  output logic [3:0]      req,
  output logic            tick
);

  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_DIV - 1);

  lane_vec_t       deb;
  lane_vec_t       req_q, req_d;
  logic [TK_W-1:0] tk_cnt_q, tk_cnt_d;
  logic            tick_q, tick_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(clk),
      .rst(rst),
      .raw(sens_raw[i]),
      .deb(deb[i])
    );
  end

  always_comb begin
    // Set dominates: a lane still demanding service keeps its request while green.
    req_d    = deb | (req_q & ~green);
    tick_d   = (tk_cnt_q == TK_MAX);
    tk_cnt_d = (tk_cnt_q == TK_MAX) ? '0 : tk_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      tk_cnt_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      req_q    <= req_d;
      tk_cnt_q <= tk_cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign req  = req_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_lane_request_conditioner.sv
// Bench for lane_request_conditioner: per-edge expected {tick,req} scoreboard.
module tb_lane_request_conditioner;

  localparam int DEB = 16;
  localparam int TDV = 5;
  localparam int LAT = DEB + 2;

  logic       clk;
  logic       rst;
  logic [3:0] sens_raw;
  logic [3:0] green;
  logic [3:0] req;
  logic       tick;

  int n_checks;
  int n_errors;
  int n_edge;
  logic [4:0] exp_q[$];

  lane_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV(TDV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sens_raw(sens_raw),
    .green(green),
    .req(req),
    .tick(tick)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {tick,req}=%b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: expected {tick,req} is pushed before the edge, popped and compared after it.
  task automatic step(input string tag, input logic [3:0] exp_req);
    logic exp_tick;
    n_edge++;
    exp_tick = ((n_edge % TDV) == 0);
    exp_q.push_back({exp_tick, exp_req});
    @(posedge clk);
    #1;
    check_eq(tag, {tick, req}, exp_q.pop_front());
  endtask

  // Reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq(tag, {tick, req}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_hold"}, {tick, req}, 5'b0);
    @(negedge clk);
    rst    = 1'b0;
    n_edge = 0;
  endtask

  task automatic run(input string tag, input int cycles, input logic [3:0] exp_req);
    for (int k = 0; k < cycles; k++) step(tag, exp_req);
  endtask

  // Sensor pattern applied before edge 0; req expected from edge LAT onward.
  task automatic run_rise(input string tag, input int cycles, input logic [3:0] before_val,
                          input logic [3:0] after_val);
    for (int k = 0; k < cycles; k++) step(tag, (k >= LAT) ? after_val : before_val);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_edge   = 0;
    rst      = 1'b1;
    sens_raw = 4'b0000;
    green    = 4'b0000;
    @(posedge clk);
    #1;
    check_eq("reset_state", {tick, req}, 5'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single lane latency, then served clear
    sens_raw = 4'b0001;
    run_rise("t1_rise", LAT + 5, 4'b0000, 4'b0001);
    sens_raw = 4'b0000;
    run("t1_held", LAT, 4'b0001);
    green = 4'b0001;
    step("t1_serve", 4'b0000);
    green = 4'b0000;
    run("t1_idle", 3, 4'b0000);

    // 2: 15-cycle glitch rejected, 16-cycle pulse accepted
    do_reset("t2_rst");
    sens_raw = 4'b0010;
    run("t2_glitch", DEB - 1, 4'b0000);
    sens_raw = 4'b0000;
    run("t2_after", LAT + 4, 4'b0000);
    sens_raw = 4'b0010;
    for (int k = 0; k < LAT + 4; k++) begin
      if (k == DEB) sens_raw = 4'b0000;
      step("t2_pulse", (k >= LAT) ? 4'b0010 : 4'b0000);
    end
    run("t2_latched", 5, 4'b0010);

    // 3: clear needs green with sensor idle; sensor still high keeps req
    do_reset("t3_rst");
    sens_raw = 4'b0100;
    run_rise("t3_rise", LAT + 1, 4'b0000, 4'b0100);
    sens_raw = 4'b0000;
    run("t3_fall", LAT, 4'b0100);
    green = 4'b0100;
    step("t3_clear", 4'b0000);
    green = 4'b0000;
    run("t3_cleared", 3, 4'b0000);
    sens_raw = 4'b0100;
    run_rise("t3_rise2", LAT + 1, 4'b0000, 4'b0100);
    green = 4'b0100;
    step("t3_set_dom", 4'b0100);
    green = 4'b0000;
    run("t3_kept", 3, 4'b0100);
    green = 4'b1011;
    step("t3_other_green", 4'b0100);
    green = 4'b0000;

    // 5: all lanes together
    do_reset("t5_rst");
    sens_raw = 4'b1111;
    run_rise("t5_rise", LAT + 2, 4'b0000, 4'b1111);
    sens_raw = 4'b0000;
    run("t5_fall", LAT, 4'b1111);
    green = 4'b1111;
    step("t5_clear", 4'b0000);
    green = 4'b0000;
    run("t5_idle", 3, 4'b0000);

    // 6: reset mid-debounce on lane B (count 10) while tick is high
    do_reset("t6_pre");
    sens_raw = 4'b0001;
    run_rise("t6_lane_a", LAT + 1, 4'b0000, 4'b0001);
    run("t6_wait", 4, 4'b0001);
    sens_raw = 4'b0011;
    run("t6_lane_b", 12, 4'b0001);
    do_reset("t6_async");
    run_rise("t6_restart", LAT + 5, 4'b0000, 4'b0011);

    // 4: tick spacing over a longer idle stretch
    do_reset("t4_rst");
    sens_raw = 4'b0000;
    run("t4_tick", 3 * TDV + 2, 4'b0000);

    for (int k = 0; k < 12; k++) begin
      sens_raw = 4'($urandom_range(0, 15));
      step("rand_short", 4'b0000);
    end
    sens_raw = 4'b0000;
    run("rand_settle", 4, 4'b0000);

    check_eq("queue_empty", 5'(exp_q.size()), 5'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
